// File: rtl/serial_pattern_pkg.sv
// Shared types and pattern constants for the serial pattern link.
package serial_pattern_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] PAT_A = 3'b111;
  localparam logic [2:0] PAT_B = 3'b001;

  // True when a three-bit window (oldest bit in [2]) completes a detector pattern.
  function automatic logic is_pattern(input logic [2:0] window);
    return (window == PAT_A) || (window == PAT_B);
  endfunction

endpackage

// File: rtl/serial_pattern_tx_pattern_predictor.sv
// Reference model of the Mealy pattern detector: tracks stream history,
// flags bits completing 111 or 001, and counts those hits (saturating).
module pattern_predictor
  import serial_pattern_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             serial_bit,
  input  logic             bit_valid,
  input  logic             clear,
  output logic             hit,
  output logic [CNT_W-1:0] count
);

  // Only the two previous bits are stored; the current bit completes the window.
  logic [1:0] hist;

  assign hit = bit_valid & is_pattern({hist, serial_bit});

  // History advances only on valid bits, so idle gaps do not break the stream.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) hist <= '0;
    else if (bit_valid) hist <= {hist[0], serial_bit};
  end

  // Saturating hit counter; clear wins over a simultaneous increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else if (clear) count <= '0;
    else if (hit && (count != '1)) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts parallel words over valid/ready and
// shifts them out MSB-first with zero-bubble back-to-back support.
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             o_bit,
  output logic             o_valid,
  output logic             o_last,
  output logic             o_hit_expect,
  output logic [CNT_W-1:0] hit_count,
  input  logic             clear_count
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             accept;

  // Ready while idle, or on the last bit of a word to allow a seamless reload.
  assign in_ready = (state == IDLE) || (idx == '0);
  assign accept   = in_valid & in_ready;

  // Next-state logic: load on handshake, count the bit index down while shifting.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_n = state;
    sreg_n  = sreg;
    idx_n   = idx;
    unique case (state)
      IDLE: begin
        if (accept) begin
          sreg_n  = in_data;
          idx_n   = IDX_W'(WIDTH - 1);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (idx == '0) begin
          if (accept) begin
            sreg_n = in_data;
            idx_n  = IDX_W'(WIDTH - 1);
          end else begin
            state_n = IDLE;
          end
        end else begin
          idx_n = idx - IDX_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, shift register and registered stream outputs, derived from next state
  // so the MSB appears in the cycle right after the accepting edge.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: the shift register is datapath but is still reset so o_bit is defined out of reset.
    if (!reset_n) begin
      state   <= IDLE;
      sreg    <= '0;
      idx     <= '0;
      o_bit   <= 1'b0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      state   <= state_n;
      sreg    <= sreg_n;
      idx     <= idx_n;
      o_valid <= (state_n == SHIFT);
      o_bit   <= (state_n == SHIFT) & sreg_n[idx_n];
      o_last  <= (state_n == SHIFT) && (idx_n == '0);
    end
  end

  pattern_predictor #(
    .CNT_W(CNT_W)
  ) u_predictor (
    .clock     (clock),
    .reset_n   (reset_n),
    .serial_bit(o_bit),
    .bit_valid (o_valid),
    .clear     (clear_count),
    .hit       (o_hit_expect),
    .count     (hit_count)
  );

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed self-checking bench for serial_pattern_tx (CNT_W=8 main instance,
// CNT_W=2 instance on the same stimulus for saturation checks).
module tb_serial_pattern_tx;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       clear_count;

  logic       in_ready, o_bit, o_valid, o_last, o_hit_expect;
  logic [7:0] hit_count;
  logic       s_in_ready, s_o_bit, s_o_valid, s_o_last, s_o_hit_expect;
  logic [1:0] s_hit_count;

  int vectors    = 0;
  int miscompares = 0;

  serial_pattern_tx #(.WIDTH(8), .CNT_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .o_bit       (o_bit),
    .o_valid     (o_valid),
    .o_last      (o_last),
    .o_hit_expect(o_hit_expect),
    .hit_count   (hit_count),
    .clear_count (clear_count)
  );

  serial_pattern_tx #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (s_in_ready),
    .o_bit       (s_o_bit),
    .o_valid     (s_o_valid),
    .o_last      (s_o_last),
    .o_hit_expect(s_o_hit_expect),
    .hit_count   (s_hit_count),
    .clear_count (clear_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // Send one word from IDLE and check every bit, hit flag, last flag and ready.
  task automatic send_word(input logic [7:0] data, input logic [7:0] hits, input string tag);
    in_data  = data;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = ~data;  // must not affect the word in flight
    for (int i = 0; i < 8; i++) begin
      check({tag, "_valid"}, o_valid, 1'b1);
      check({tag, "_bit"}, o_bit, data[7-i]);
      check({tag, "_hit"}, o_hit_expect, hits[7-i]);
      check({tag, "_last"}, o_last, (i == 7));
      check({tag, "_ready"}, in_ready, (i == 7));
      tick();
    end
    check({tag, "_idle_valid"}, o_valid, 1'b0);
  endtask

  logic [15:0] b2b_bits;
  logic [15:0] b2b_hits;

  initial begin
    reset_n     = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    clear_count = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_ready", in_ready, 1'b1);
    check("rst_valid", o_valid, 1'b0);
    check("rst_count", hit_count, 8'd0);
    check("rst_bit", o_bit, 1'b0);
    reset_n = 1'b1;
    tick();
    check("post_rst_ready", in_ready, 1'b1);
    check("post_rst_valid", o_valid, 1'b0);

    // Single word 1011_0111: hits on bit 1 (001) and bit 8 (111)
    send_word(8'b1011_0111, 8'b1000_0001, "single");
    check("single_count", hit_count, 8'd2);

    // Back-to-back FF then 00 with in_valid held high
    do_reset();
    b2b_bits = 16'hFF00;
    b2b_hits = 16'b1011_1111_0000_0000;
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      check("b2b_valid", o_valid, 1'b1);
      check("b2b_bit", o_bit, b2b_bits[15-i]);
      check("b2b_hit", o_hit_expect, b2b_hits[15-i]);
      check("b2b_last", o_last, (i == 7) || (i == 15));
      if (i == 7) in_data = 8'h00;
      if (i == 15) in_valid = 1'b0;
      tick();
    end
    check("b2b_idle_valid", o_valid, 1'b0);
    check("b2b_count", hit_count, 8'd7);
    check("sat_count_ff", s_hit_count, 2'd3);

    // Clear on a hit cycle: history is 000, so FF hits on bits 1,3..8
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("clr_bit1_hit", o_hit_expect, 1'b1);
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    check("clr_count_main", hit_count, 8'd0);
    check("clr_count_sat", s_hit_count, 2'd0);
    check("clr_bit2_hit", o_hit_expect, 1'b0);
    tick();
    check("clr_bit3_hit", o_hit_expect, 1'b1);
    tick();
    check("clr_next_hit_sat", s_hit_count, 2'd1);
    repeat (5) tick();
    check("clr_end_main", hit_count, 8'd6);
    check("clr_end_sat", s_hit_count, 2'd3);

    // Gap continuity: 01, five idle cycles, then 80 (history 011 -> no hit)
    do_reset();
    send_word(8'h01, 8'b0000_0001, "gap_a");
    for (int i = 0; i < 5; i++) begin
      check("gap_idle_valid", o_valid, 1'b0);
      tick();
    end
    send_word(8'h80, 8'b0000_0000, "gap_b");
    check("gap_count", hit_count, 8'd1);

    // Asynchronous reset mid-word (during bit 4 of AA)
    do_reset();
    in_data  = 8'hAA;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mid_bit4_valid", o_valid, 1'b1);
    check("mid_pre_count", hit_count, 8'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", o_valid, 1'b0);
    check("mid_rst_bit", o_bit, 1'b0);
    check("mid_rst_last", o_last, 1'b0);
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_rst_count", hit_count, 8'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("mid_release_valid", o_valid, 1'b0);
    send_word(8'h80, 8'b1000_0000, "mid_after");
    check("mid_after_count", hit_count, 8'd1);
    check("mid_after_sat", s_hit_count, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
